// File: rtl/call_stack_seq.sv
// call_stack_seq
//   Call/return sequencer beside the control unit. Owns the byte-wide stack
//   memory port: a CALL pushes the 16-bit return address (high byte first)
//   and hands the target back as the next PC. A RET pops two bytes (low
//   byte first) and hands them back as the next PC. The stack is
//   empty-descending: SP points at the next free byte.
//
//   Optional build macro: CALL_STACK_GUARD_EN
//     defined   - calls with fewer than 2 free bytes and returns with fewer
//                 than 2 stacked bytes are faulted. They skip the memory
//                 access and report o_fault in DONE.
//     undefined - no checks, SP wraps freely, o_fault is tied to 0.
//
//   Parameters
//     ADDR_W   - PC/SP/address width (byte packing assumes 16)
//     SP_INIT  - SP reset value
//     SP_LIMIT - lowest legal stack byte (guard build only)
//
//   Ports
//     i_clk, i_rst          clock, async active-high reset
//     i_call, i_ret         requests, sampled only in IDLE (call wins)
//     i_target, i_ret_pc    call target / return address, captured with i_call
//     o_busy, o_done        non-IDLE flag, one-cycle completion pulse
//     o_pc_load, o_pc       next-PC valid strobe and value
//     o_sp                  current stack pointer
//     o_mem_*, i_mem_*      byte memory port, req held until ack
//     o_fault               overflow/underflow pulse in DONE
//
//   state   | meaning
//   IDLE    | waiting for a call or return request
//   PUSH_HI | writing return-address high byte at SP
//   PUSH_LO | writing return-address low byte at SP
//   POP_LO  | reading low byte at SP+1
//   POP_HI  | reading high byte at SP+1
//   DONE    | completion pulse, back to IDLE next cycle
module call_stack_seq #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  SP_INIT  = 16'hFFFF,
    parameter logic [ADDR_W-1:0]  SP_LIMIT = 16'hFF00
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic [ADDR_W-1:0] i_target,
    input  logic [ADDR_W-1:0] i_ret_pc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_fault
);

`ifdef CALL_STACK_GUARD_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_HI = 3'd1,
        S_PUSH_LO = 3'd2,
        S_POP_LO  = 3'd3,
        S_POP_HI  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ret_pc;
    logic [7:0]        lo_byte;
    logic              fault_q;
    logic              call_fault;
    logic              ret_fault;
    logic              is_push;
    logic              is_pop;

    // Constant-folds to 0 in the unguarded build.
    assign call_fault = GUARD_EN && (sp < SP_LIMIT + ADDR_W'(1));
    assign ret_fault  = GUARD_EN && (sp > SP_INIT - ADDR_W'(2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_call) begin
                    state_nxt = call_fault ? S_DONE : S_PUSH_HI;
                end else if (i_ret) begin
                    state_nxt = ret_fault ? S_DONE : S_POP_LO;
                end
            end
            S_PUSH_HI: if (i_mem_ack) state_nxt = S_PUSH_LO;
            S_PUSH_LO: if (i_mem_ack) state_nxt = S_DONE;
            S_POP_LO:  if (i_mem_ack) state_nxt = S_POP_HI;
            S_POP_HI:  if (i_mem_ack) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp      <= SP_INIT;
            pc      <= '0;
            target  <= '0;
            ret_pc  <= '0;
            lo_byte <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_call) begin
                        target  <= i_target;
                        ret_pc  <= i_ret_pc;
                        fault_q <= call_fault;
                    end else if (i_ret) begin
                        fault_q <= ret_fault;
                    end
                end
                S_PUSH_HI: begin
                    if (i_mem_ack) sp <= sp - ADDR_W'(1);
                end
                S_PUSH_LO: begin
                    if (i_mem_ack) begin
                        sp <= sp - ADDR_W'(1);
                        pc <= target;
                    end
                end
                S_POP_LO: begin
                    if (i_mem_ack) begin
                        lo_byte <= i_mem_rdata;
                        sp      <= sp + ADDR_W'(1);
                    end
                end
                S_POP_HI: begin
                    if (i_mem_ack) begin
                        pc <= ADDR_W'({i_mem_rdata, lo_byte});
                        sp <= sp + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state, so nothing in the memory
    // request can move while an access is pending.
    assign is_push = (state == S_PUSH_HI) || (state == S_PUSH_LO);
    assign is_pop  = (state == S_POP_LO)  || (state == S_POP_HI);

    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_pc_load   = (state == S_DONE) && !fault_q;
    assign o_pc        = pc;
    assign o_sp        = sp;
    assign o_mem_req   = is_push || is_pop;
    assign o_mem_we    = is_push;
    assign o_mem_addr  = is_push ? sp : (is_pop ? sp + ADDR_W'(1) : '0);
    assign o_mem_wdata = (state == S_PUSH_HI) ? ret_pc[15:8] :
                         (state == S_PUSH_LO) ? ret_pc[7:0]  : 8'h00;

`ifdef CALL_STACK_GUARD_EN
    assign o_fault = (state == S_DONE) && fault_q;
`else
    assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack_seq.sv
module tb_call_stack_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_call;
    logic        i_ret;
    logic [15:0] i_target;
    logic [15:0] i_ret_pc;
    logic        o_busy;
    logic        o_done;
    logic        o_pc_load;
    logic [15:0] o_pc;
    logic [15:0] o_sp;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic        i_mem_ack;
    logic [7:0]  i_mem_rdata;
    logic        o_fault;

    call_stack_seq dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_call      (i_call),
        .i_ret       (i_ret),
        .i_target    (i_target),
        .i_ret_pc    (i_ret_pc),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pc_load   (o_pc_load),
        .o_pc        (o_pc),
        .o_sp        (o_sp),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_fault     (o_fault)
    );

    always #5 i_clk = ~i_clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  mem [0:65535];
    int          wait_n = 0;
    int          acc_n;
    logic        acc_we   [0:7];
    logic [15:0] acc_addr [0:7];
    logic [7:0]  acc_data [0:7];
    int          unstable;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Memory responder: acks after wait_n idle cycles, logs each access and
    // counts any change of the request while it is pending.
    initial begin
        int          cnt;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic        we0;
        cnt = 0; a0 = '0; d0 = '0; we0 = 1'b0;
        i_mem_ack = 1'b0;
        i_mem_rdata = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst || !o_mem_req) begin
                i_mem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    a0 = o_mem_addr; d0 = o_mem_wdata; we0 = o_mem_we;
                end else if (o_mem_addr != a0 || o_mem_wdata != d0 || o_mem_we != we0) begin
                    unstable++;
                end
                if (cnt == wait_n) begin
                    i_mem_ack = 1'b1;
                    if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
                    else          i_mem_rdata = mem[o_mem_addr];
                    if (acc_n < 8) begin
                        acc_we[acc_n]   = o_mem_we;
                        acc_addr[acc_n] = o_mem_addr;
                        acc_data[acc_n] = o_mem_we ? o_mem_wdata : mem[o_mem_addr];
                    end
                    acc_n++;
                    cnt = 0;
                end else begin
                    i_mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Issues one request at edge 0 and returns in the DONE cycle (cycle index
    // done_at counted from 1 after the sampling edge). An i_ret pulse can be
    // injected in cycle ret_pulse_at.
    task automatic run_op(input logic c, input logic r, input logic [15:0] tgt,
                          input logic [15:0] rpc, input int ret_pulse_at,
                          output int done_at, output int busy_n);
        acc_n = 0;
        unstable = 0;
        i_call = c; i_ret = r; i_target = tgt; i_ret_pc = rpc;
        step();
        i_call = 1'b0; i_ret = 1'b0;
        done_at = 0;
        busy_n = 0;
        for (int n = 1; n <= 60; n++) begin
            i_ret = (n == ret_pulse_at);
            if (o_busy) busy_n++;
            if (o_done) begin
                done_at = n;
                break;
            end
            step();
        end
        i_ret = 1'b0;
        if (done_at == 0) check_val("done_timeout", 32'(done_at), 32'd1);
    endtask

    initial begin
        int d, b;
        i_rst = 1'b1;
        i_call = 1'b0; i_ret = 1'b0; i_target = '0; i_ret_pc = '0;
        acc_n = 0; unstable = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[0] = 8'h77;
        mem[1] = 8'h66;

        // reset values
        step(); step();
        check_val("rst_sp",    32'(o_sp), 32'hFFFF);
        check_val("rst_pc",    32'(o_pc), 32'h0000);
        check_val("rst_busy",  32'(o_busy), 32'd0);
        check_val("rst_done",  32'(o_done), 32'd0);
        check_val("rst_load",  32'(o_pc_load), 32'd0);
        check_val("rst_fault", 32'(o_fault), 32'd0);
        check_val("rst_req",   32'(o_mem_req), 32'd0);
        check_val("rst_we",    32'(o_mem_we), 32'd0);
        check_val("rst_addr",  32'(o_mem_addr), 32'h0000);
        check_val("rst_wdata", 32'(o_mem_wdata), 32'h00);
        i_rst = 1'b0;
        step();

        // call, zero wait
        run_op(1'b1, 1'b0, 16'h4000, 16'h0123, 0, d, b);
        check_val("call0_done_cyc", 32'(d), 32'd3);
        check_val("call0_busy_cyc", 32'(b), 32'd3);
        check_val("call0_pc",   32'(o_pc), 32'h4000);
        check_val("call0_load", 32'(o_pc_load), 32'd1);
        check_val("call0_fault", 32'(o_fault), 32'd0);
        check_val("call0_sp",   32'(o_sp), 32'hFFFD);
        check_val("call0_nacc", 32'(acc_n), 32'd2);
        check_val("call0_we0",  32'(acc_we[0]), 32'd1);
        check_val("call0_a0",   32'(acc_addr[0]), 32'hFFFF);
        check_val("call0_d0",   32'(acc_data[0]), 32'h01);
        check_val("call0_a1",   32'(acc_addr[1]), 32'hFFFE);
        check_val("call0_d1",   32'(acc_data[1]), 32'h23);
        step();
        check_val("call0_idle", 32'(o_busy), 32'd0);

        // return, zero wait
        run_op(1'b0, 1'b1, 16'h0000, 16'h0000, 0, d, b);
        check_val("ret0_done_cyc", 32'(d), 32'd3);
        check_val("ret0_pc",   32'(o_pc), 32'h0123);
        check_val("ret0_load", 32'(o_pc_load), 32'd1);
        check_val("ret0_sp",   32'(o_sp), 32'hFFFF);
        check_val("ret0_nacc", 32'(acc_n), 32'd2);
        check_val("ret0_we0",  32'(acc_we[0]), 32'd0);
        check_val("ret0_a0",   32'(acc_addr[0]), 32'hFFFE);
        check_val("ret0_a1",   32'(acc_addr[1]), 32'hFFFF);
        step();

        // call with 2 wait cycles per access, then return with 1
        wait_n = 2;
        run_op(1'b1, 1'b0, 16'h1234, 16'hBEEF, 0, d, b);
        check_val("call2_done_cyc", 32'(d), 32'd7);
        check_val("call2_stable", 32'(unstable), 32'd0);
        check_val("call2_d0",  32'(acc_data[0]), 32'hBE);
        check_val("call2_d1",  32'(acc_data[1]), 32'hEF);
        check_val("call2_pc",  32'(o_pc), 32'h1234);
        check_val("call2_sp",  32'(o_sp), 32'hFFFD);
        step();
        wait_n = 1;
        run_op(1'b0, 1'b1, 16'h0000, 16'h0000, 0, d, b);
        check_val("ret1_done_cyc", 32'(d), 32'd5);
        check_val("ret1_stable", 32'(unstable), 32'd0);
        check_val("ret1_pc",  32'(o_pc), 32'hBEEF);
        check_val("ret1_sp",  32'(o_sp), 32'hFFFF);
        step();
        wait_n = 0;

        // call and ret together, ret pulsed again in PUSH_LO
        run_op(1'b1, 1'b1, 16'h2468, 16'h5A5A, 2, d, b);
        check_val("both_done_cyc", 32'(d), 32'd3);
        check_val("both_nacc", 32'(acc_n), 32'd2);
        check_val("both_we1",  32'(acc_we[1]), 32'd1);
        check_val("both_pc",   32'(o_pc), 32'h2468);
        check_val("both_sp",   32'(o_sp), 32'hFFFD);
        step();
        check_val("both_idle1", 32'(o_busy), 32'd0);
        step();
        check_val("both_idle2", 32'(o_busy), 32'd0);
        run_op(1'b0, 1'b1, 16'h0000, 16'h0000, 0, d, b);
        check_val("both_ret_pc", 32'(o_pc), 32'h5A5A);
        check_val("both_ret_sp", 32'(o_sp), 32'hFFFF);
        step();

        // reset in PUSH_LO
        wait_n = 2;
        i_call = 1'b1; i_target = 16'h1111; i_ret_pc = 16'h2222;
        step();
        i_call = 1'b0;
        step(); step(); step();
        check_val("rmid_req_pre",  32'(o_mem_req), 32'd1);
        check_val("rmid_addr_pre", 32'(o_mem_addr), 32'hFFFE);
        i_rst = 1'b1;
        #1;
        check_val("rmid_req",  32'(o_mem_req), 32'd0);
        check_val("rmid_sp",   32'(o_sp), 32'hFFFF);
        check_val("rmid_busy", 32'(o_busy), 32'd0);
        step();
        i_rst = 1'b0;
        wait_n = 0;
        step();
        check_val("rmid_idle",    32'(o_busy), 32'd0);
        check_val("rmid_sp_post", 32'(o_sp), 32'hFFFF);

        // return from empty stack
        run_op(1'b0, 1'b1, 16'h0000, 16'h0000, 0, d, b);
`ifdef CALL_STACK_GUARD_EN
        check_val("uflow_done_cyc", 32'(d), 32'd1);
        check_val("uflow_fault", 32'(o_fault), 32'd1);
        check_val("uflow_load",  32'(o_pc_load), 32'd0);
        check_val("uflow_nacc",  32'(acc_n), 32'd0);
        check_val("uflow_sp",    32'(o_sp), 32'hFFFF);
        check_val("uflow_pc",    32'(o_pc), 32'h0000);
`else
        check_val("uflow_done_cyc", 32'(d), 32'd3);
        check_val("uflow_fault", 32'(o_fault), 32'd0);
        check_val("uflow_load",  32'(o_pc_load), 32'd1);
        check_val("uflow_a0",    32'(acc_addr[0]), 32'h0000);
        check_val("uflow_pc",    32'(o_pc), 32'h6677);
        check_val("uflow_sp",    32'(o_sp), 32'h0001);
`endif
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();

        // fill the stack down to FEFF, then one more call
        for (int k = 0; k < 128; k++) begin
            run_op(1'b1, 1'b0, 16'(k), 16'(k), 0, d, b);
            step();
        end
        check_val("fill_sp", 32'(o_sp), 32'hFEFF);
        check_val("fill_pc", 32'(o_pc), 32'h007F);
        run_op(1'b1, 1'b0, 16'hABCD, 16'h1357, 0, d, b);
`ifdef CALL_STACK_GUARD_EN
        check_val("oflow_done_cyc", 32'(d), 32'd1);
        check_val("oflow_fault", 32'(o_fault), 32'd1);
        check_val("oflow_load",  32'(o_pc_load), 32'd0);
        check_val("oflow_nacc",  32'(acc_n), 32'd0);
        check_val("oflow_sp",    32'(o_sp), 32'hFEFF);
        check_val("oflow_pc",    32'(o_pc), 32'h007F);
`else
        check_val("oflow_done_cyc", 32'(d), 32'd3);
        check_val("oflow_fault", 32'(o_fault), 32'd0);
        check_val("oflow_a0",    32'(acc_addr[0]), 32'hFEFF);
        check_val("oflow_d0",    32'(acc_data[0]), 32'h13);
        check_val("oflow_sp",    32'(o_sp), 32'hFEFD);
        check_val("oflow_pc",    32'(o_pc), 32'hABCD);
`endif
        step();
        check_val("end_idle", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/call_stack_seq.md
# call_stack_seq

Hardware call/return sequencer that sits beside the `control_unit` and owns the byte-wide stack-memory port for CALL (opcode 0xC1) and RET. When the control unit issues a call, the sequencer pushes the 16-bit return address as two bytes, updates the stack pointer and hands the target back as the next PC. When the control unit issues a return, it pops two bytes and returns them as the next PC. The control unit stalls on `o_busy` and resumes on `o_done`.

## Interface
- `ADDR_W`, 16 — PC, SP and memory address width.
- `SP_INIT`, 16'hFFFF — SP reset value. The stack is empty-descending: SP points at the next free byte.
- `SP_LIMIT`, 16'hFF00 — lowest legal stack byte. Used only when the guard is compiled in.
---
- `i_clk` in 1 — clock; all logic rising-edge.
- `i_rst` in 1 — reset; asynchronous, active-high.
- `i_call` in 1 — call request; sampled only in IDLE.
- `i_ret` in 1 — return request; sampled only in IDLE.
- `i_target` in ADDR_W — call target; captured with `i_call`.
- `i_ret_pc` in ADDR_W — return address to push; captured with `i_call`.
- `o_busy` in/out: out 1 — high in every non-IDLE state.
- `o_done` out 1 — one-cycle completion pulse.
- `o_pc_load` out 1 — high with `o_done` when `o_pc` is valid.
- `o_pc` out ADDR_W — next PC; holds its value until the next completion.
- `o_sp` out ADDR_W — current stack pointer.
- `o_mem_req` out 1 — memory access request.
- `o_mem_we` out 1 — 1 = write, 0 = read.
- `o_mem_addr` out ADDR_W — memory byte address.
- `o_mem_wdata` out 8 — memory write data.
- `i_mem_ack` in 1 — access complete; read data is valid in the same cycle.
- `i_mem_rdata` in 8 — memory read byte.
- `o_fault` out 1 — overflow/underflow pulse; tied to 0 without the guard.

## Operation
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, DONE.
- IDLE → PUSH_HI on `i_call`. Captures `i_target` and `i_ret_pc`.
- IDLE → POP_LO on `i_ret` with `i_call` low.
- Simultaneous `i_call` and `i_ret`: the call wins and the return is dropped, not queued.
- Requests arriving outside IDLE are ignored.
- PUSH_HI:
  - Drives write of `ret_pc[15:8]` to SP.
  - On ack: SP ← SP−1, go to PUSH_LO.
- PUSH_LO:
  - Drives write of `ret_pc[7:0]` to SP.
  - On ack: SP ← SP−1, `o_pc` ← target, go to DONE.
- POP_LO:
  - Drives read at SP+1.
  - On ack: latch the low byte, SP ← SP+1, go to POP_HI.
- POP_HI:
  - Drives read at SP+1.
  - On ack: `o_pc` ← {rdata, low byte}, SP ← SP+1, go to DONE.
- DONE:
  - `o_done` = 1; `o_pc_load` = 1 unless faulted.
  - Goes to IDLE unconditionally next cycle.
- Handshake:
  - `o_mem_req`, `o_mem_we`, `o_mem_addr` and `o_mem_wdata` are held stable while the access is pending.
  - The state advances only on a cycle where `i_mem_ack` is high.
  - Zero-wait ack (ack in the first req cycle) is legal.
  - `i_mem_ack` is ignored when `o_mem_req` is low.
- SP arithmetic is modulo 2^ADDR_W.
- Reset values:
  - state = IDLE, `o_sp` = SP_INIT, `o_pc` = 0.
  - `o_busy`, `o_done`, `o_pc_load`, `o_fault`, `o_mem_req`, `o_mem_we` = 0.
  - `o_mem_addr` = 0, `o_mem_wdata` = 0.
- Reset mid-operation:
  - Asynchronously returns everything to reset values and drops `o_mem_req` at once.
  - A partial push or pop is abandoned; SP is restored to SP_INIT.

## Timing
- Moore outputs, decoded from registered state and registers; no combinational input→output paths.
- Request sampled at edge 0, zero-wait memory:
  - req high in cycles 1–2.
  - `o_done` high in cycle 3.
  - IDLE in cycle 4.
  - Total 3 cycles busy.
- Each memory wait cycle adds one cycle.
- `o_busy` rises the cycle after the sampling edge and is still high during DONE.

## Configuration
- Macro: `CALL_STACK_GUARD_EN`.
- When defined:
  - A call is faulted when SP < SP_LIMIT+1, i.e. fewer than 2 free bytes.
  - A return is faulted when SP > SP_INIT−2, i.e. fewer than 2 stacked bytes.
  - A faulted request goes straight to DONE with no memory access.
  - In DONE: `o_fault` = 1, `o_pc_load` = 0; SP and `o_pc` are unchanged.
- When undefined:
  - No checks are made; SP wraps freely.
  - `o_fault` is tied to 0.

## Test plan
- Call with zero-wait ack, `i_ret_pc`=16'h0123, `i_target`=16'h4000, from reset:
  - Writes 8'h01 to FFFF, then 8'h23 to FFFE.
  - `o_done` and `o_pc_load` with `o_pc`=4000, `o_sp`=FFFD; 3 cycles busy.
- Return immediately after that call, memory returning 8'h23 then 8'h01:
  - Reads FFFE then FFFF.
  - `o_pc`=0123, `o_sp`=FFFF.
- Call with 2 wait cycles per access:
  - Address and data stable while pending; `o_done` in cycle 7.
- `i_call` and `i_ret` high together in IDLE:
  - Only the push sequence runs.
  - `i_ret` pulsed during PUSH_LO is ignored.
- `i_rst` asserted in PUSH_LO:
  - `o_mem_req`=0 in the same cycle.
  - `o_sp`=FFFF, state IDLE after release.
- Guard on, SP_LIMIT=FF00, 128 calls (SP reaches FEFF), then a 129th call:
  - `o_fault`=1, no req, `o_sp`=FEFF.
- Guard on, return from reset: `o_fault`=1.
- Guard off, same two cases: `o_fault`=0 and SP wraps.
